// File: rtl/tetris_pkg.sv
// Shared definitions for the button command path: button count and command codes.
package tetris_pkg;

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned CMD_W   = 2;

  typedef enum logic [CMD_W-1:0] {
    SHIFT_L = 2'd0,
    ROT     = 2'd1,
    COLOR   = 2'd2,
    SHIFT_R = 2'd3
  } cmd_e;

endpackage

// File: rtl/btn_debounce.sv
// One button: sampling flop, stability counter, debounced level and a single-cycle rise pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_c
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  // The level flips on the same edge the mismatch count reaches DEBOUNCE_CYCLES.
  always_comb begin
    hit     = (sync_q != level_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    cnt_d   = cnt_q;
    level_d = level_q;
    if ((sync_q == level_q) || hit) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (hit) begin
      level_d = ~level_q;
    end
    rise_c = hit && !level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= btn_i;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/button_cmd_scheduler.sv
// Debounced push-buttons -> pending flags -> lowest-index arbiter -> command FIFO.
// Optional auto-repeat of held buttons is enabled by defining AUTO_REPEAT_EN.
module button_cmd_scheduler
  import tetris_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_BTN-1:0]            button,
  output logic                          cmd_valid,
  output logic [CMD_W-1:0]              cmd,
  input  logic                          cmd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (REPEAT_DELAY == 0) || (REPEAT_PERIOD == 0)) begin : g_bad_cfg
    $error("button_cmd_scheduler: illegal parameter set");
  end

  logic [NUM_BTN-1:0] level, rise, press_ev;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (button[g]),
      .level_o (level[g]),
      .rise_c  (rise[g])
    );
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [NUM_BTN-1:0][REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [NUM_BTN-1:0]            in_delay_q, in_delay_d, rep_fire;

  // in_delay marks the long first wait; after the first repeat the short period applies.
  always_comb begin
    rep_cnt_d  = rep_cnt_q;
    in_delay_d = in_delay_q;
    rep_fire   = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      if (!level[i]) begin
        rep_cnt_d[i]  = '0;
        in_delay_d[i] = 1'b1;
      end else begin
        rep_fire[i] = in_delay_q[i] ? (rep_cnt_q[i] == REP_W'(REPEAT_DELAY - 1))
                                    : (rep_cnt_q[i] == REP_W'(REPEAT_PERIOD - 1));
        if (rep_fire[i]) begin
          rep_cnt_d[i]  = '0;
          in_delay_d[i] = 1'b0;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q  <= '0;
      in_delay_q <= '1;
    end else begin
      rep_cnt_q  <= rep_cnt_d;
      in_delay_q <= in_delay_d;
    end
  end

  assign press_ev = rise | rep_fire;
`else
  assign press_ev = rise;
`endif

  logic [NUM_BTN-1:0]                  pending_q, pending_d;
  logic [FIFO_DEPTH-1:0][CMD_W-1:0]    mem_q;
  logic [PTR_W-1:0]                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                    count_q, count_d;
  logic                                valid_q, valid_d;
  logic                                overflow_q, overflow_d;
  logic                                push, pop;
  cmd_e                                push_cmd;

  // Fullness uses the registered count only, so a same-edge pop never frees a slot early.
  always_comb begin
    push_cmd = SHIFT_L;
    for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
      if (pending_q[i]) push_cmd = cmd_e'(CMD_W'(i));
    end
    push = (|pending_q) && (count_q < CNT_W'(FIFO_DEPTH));
    pop  = (count_q != '0) && cmd_ready;

    pending_d = pending_q;
    if (push) pending_d[push_cmd] = 1'b0;
    overflow_d = overflow_q | (|(press_ev & pending_q));
    pending_d  = pending_d | (press_ev & ~pending_q);

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      if (push) mem_q[wr_ptr_q] <= push_cmd;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign cmd_valid  = valid_q;
  assign cmd        = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Directed bench for button_cmd_scheduler: a default-depth instance and a depth-2 instance.
module tb_button_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_a, btn_b;
  logic       rdy_a, rdy_b;
  logic       va, vb, ovf_a, ovf_b;
  logic [1:0] cmd_a, cmd_b;
  logic [2:0] cnt_a;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_cmd_scheduler u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (btn_a),
    .cmd_valid  (va),
    .cmd        (cmd_a),
    .cmd_ready  (rdy_a),
    .fifo_count (cnt_a),
    .overflow   (ovf_a)
  );

  button_cmd_scheduler #(.FIFO_DEPTH(2)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (btn_b),
    .cmd_valid  (vb),
    .cmd        (cmd_b),
    .cmd_ready  (rdy_b),
    .fifo_count (cnt_b),
    .overflow   (ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int vsum;
    logic exp_v;

    rst_n = 1'b0;
    btn_a = '0; btn_b = '0;
    rdy_a = 1'b0; rdy_b = 1'b0;
    tick(2);
    check("rst_valid", 32'(va), 32'(0));
    check("rst_cmd", 32'(cmd_a), 32'(0));
    check("rst_count", 32'(cnt_a), 32'(0));
    check("rst_ovf", 32'(ovf_a), 32'(0));
    rst_n = 1'b1;
    tick(2);

    // Single press: valid only after edge 5, for one cycle, code 0.
    rdy_a = 1'b1;
    btn_a = 4'b0001;
    for (int e = 0; e < 10; e++) begin
      tick(1);
      check($sformatf("t1_valid_e%0d", e), 32'(va), 32'(e == 5));
      if (e == 5) check("t1_cmd", 32'(cmd_a), 32'(0));
    end
    btn_a = 4'b0000;
    vsum = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      vsum += 32'(va);
    end
    check("t1_release_quiet", 32'(vsum), 32'(0));

    // Bounce shorter than the debounce window produces nothing.
    vsum = 0;
    for (int k = 0; k < 20; k++) begin
      btn_a = (((k / 2) % 2) == 0) ? 4'b0001 : 4'b0000;
      tick(1);
      vsum += 32'(va);
    end
    btn_a = 4'b0000;
    tick(8);
    check("t2_no_cmd", 32'(vsum), 32'(0));
    check("t2_ovf", 32'(ovf_a), 32'(0));

    // All four together with ready low: count fills 1..4, then drains 0,1,2,3.
    rdy_a = 1'b0;
    btn_a = 4'b1111;
    for (int e = 0; e < 9; e++) begin
      tick(1);
      if (e >= 4) check($sformatf("t3_count_e%0d", e), 32'(cnt_a), 32'(e - 4));
    end
    check("t3_cmd0", 32'(cmd_a), 32'(0));
    rdy_a = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick(1);
      check($sformatf("t3_cmd%0d", k), 32'(cmd_a), 32'(k));
    end
    tick(1);
    check("t3_drained", 32'(va), 32'(0));
    check("t3_ovf", 32'(ovf_a), 32'(0));
    btn_a = 4'b0000;
    rdy_a = 1'b0;
    tick(8);

`ifndef AUTO_REPEAT_EN
    // Depth-2 saturation: bit2 waits pending and enters on the edge after the first pop.
    btn_b = 4'b0001;
    tick(10);
    check("t4_count1", 32'(cnt_b), 32'(1));
    btn_b = 4'b0011;
    tick(10);
    check("t4_count2", 32'(cnt_b), 32'(2));
    btn_b = 4'b0111;
    tick(10);
    check("t4_full", 32'(cnt_b), 32'(2));
    check("t4_head", 32'(cmd_b), 32'(0));
    rdy_b = 1'b1;
    tick(1);
    rdy_b = 1'b0;
    check("t4_after_pop", 32'(cnt_b), 32'(1));
    check("t4_head_after_pop", 32'(cmd_b), 32'(1));
    tick(1);
    check("t4_refill", 32'(cnt_b), 32'(2));
    check("t4_ovf", 32'(ovf_b), 32'(0));

    // Re-press bit0 while it is still pending behind a full FIFO.
    btn_b = 4'b0110; tick(8);
    btn_b = 4'b0111; tick(8);
    check("t5_ovf_first", 32'(ovf_b), 32'(0));
    btn_b = 4'b0110; tick(8);
    btn_b = 4'b0111; tick(8);
    check("t5_ovf_set", 32'(ovf_b), 32'(1));
    rdy_b = 1'b1;
    check("t5_drain0", 32'(cmd_b), 32'(1));
    tick(1);
    check("t5_drain1", 32'(cmd_b), 32'(2));
    tick(1);
    check("t5_drain2", 32'(cmd_b), 32'(0));
    tick(1);
    check("t5_empty", 32'(vb), 32'(0));
    rdy_b = 1'b0;
    tick(4);
    check("t5_ovf_sticky", 32'(ovf_b), 32'(1));
`endif

    // Reset mid-operation clears immediately; a button held through release is a new press.
    btn_a = 4'b1000;
    tick(10);
    check("t6_count_pre", 32'(cnt_a), 32'(1));
    check("t6_cmd_pre", 32'(cmd_a), 32'(3));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(va), 32'(0));
    check("t6_rst_count", 32'(cnt_a), 32'(0));
    check("t6_rst_cmd", 32'(cmd_a), 32'(0));
    check("t6_rst_ovf_b", 32'(ovf_b), 32'(0));
    check("t6_rst_count_b", 32'(cnt_b), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rdy_a = 1'b1;
    for (int e = 0; e < 40; e++) begin
      tick(1);
      exp_v = (e == 5);
`ifdef AUTO_REPEAT_EN
      exp_v = exp_v || (e == 21) || (e == 29) || (e == 37);
`endif
      check($sformatf("t6_valid_e%0d", e), 32'(va), 32'(exp_v));
      if (exp_v) check($sformatf("t6_cmd_e%0d", e), 32'(cmd_a), 32'(3));
    end
    btn_a = 4'b0000;
    tick(8);
    check("t6_ovf_a", 32'(ovf_a), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
